imem_port_arbiter: RTL and testbench

//  Shares the single byte-addressable program/data memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_pkg.sv | 28 ++
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/imem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// default memory geometry, arbitration select encoding and the range check.
package mem_pkg;

    localparam int unsigned DEF_MEM_SIZE  = 4096;
    localparam logic [31:0] DEF_START_POS = 32'hbfc00000;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_I,
        SEL_D
    } arb_sel_e;

    // Word-aligned range check done in 33 bits so an address below the base
    // cannot wrap around into the valid window.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] start_pos,
                                      input logic [31:0] mem_size);
        logic [32:0] word;
        logic [32:0] lo;
        logic [32:0] hi;
        word = {1'b0, addr & 32'hFFFF_FFFC};
        lo   = {1'b0, start_pos};
        hi   = lo + {1'b0, mem_size} - 33'd4;
        return (word >= lo) && (word <= hi);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles a requester was refused.
// at_max tells the arbiter the requester must win the next arbitration.
module arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt;

    // Count refused cycles; any grant or a dropped request restarts the count.
    always_ff @(posedge clk) begin
        if (rst || !req || gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign at_max = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one byte-addressable memory port between instruction fetch (I) and
// load/store (D). D normally wins; I wins once it has been refused MAX_WAIT
// cycles in a row. Out-of-range accesses answer with an error and never reach
// the memory. Optional macro ARB_PERF_EN adds stall/grant performance counters.
module imem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
    parameter logic [31:0] START_POS = DEF_START_POS,
    parameter int unsigned MAX_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] m_addr,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_i_stall,
    output logic [31:0] perf_d_grant
`endif
);

    arb_sel_e    sel;
    logic        at_max;
    logic        i_ok;
    logic        d_ok;
    logic [31:0] win_addr;
    logic [31:0] m_addr_q;
    logic        i_rvalid_q;
    logic        i_err_q;
    logic        d_rvalid_q;
    logic        d_err_q;

    arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .req   (i_req),
        .gnt   (i_gnt),
        .at_max(at_max)
    );

    assign i_ok = in_range(i_addr, START_POS, MEM_SIZE);
    assign d_ok = in_range(d_addr, START_POS, MEM_SIZE);

    // Pick at most one winner; a starved fetch overrides the D priority.
    always_comb begin
        sel = SEL_NONE;
        if (!rst) begin
            if (at_max && i_req) begin
                sel = SEL_I;
            end else if (d_req) begin
                sel = SEL_D;
            end else if (i_req) begin
                sel = SEL_I;
            end
        end
    end

    assign i_gnt = (sel == SEL_I);
    assign d_gnt = (sel == SEL_D);

    // Drive the memory from the winner; idle cycles keep the previous address.
    always_comb begin
        win_addr = (sel == SEL_D) ? d_addr : i_addr;
        if (sel != SEL_NONE) begin
            m_addr = (win_addr & 32'hFFFF_FFFC) - START_POS;
        end else begin
            m_addr = m_addr_q;
        end
    end

    assign m_we    = d_gnt && d_we && d_ok;
    assign m_be    = d_be;
    assign m_wdata = d_wdata;

    // Remember the last driven memory address for idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_addr_q <= '0;
        end else begin
            m_addr_q <= m_addr;
        end
    end

    // Capture read data and flags for the granted port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata    <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_rvalid_q <= i_gnt;
            i_err_q    <= i_gnt && !i_ok;
            if (i_gnt) begin
                i_rdata <= i_ok ? m_rdata : '0;
            end
            d_rvalid_q <= d_gnt;
            d_err_q    <= d_gnt && !d_ok;
            if (d_gnt) begin
                d_rdata <= (d_ok && !d_we) ? m_rdata : '0;
            end
        end
    end

    // Reset landing on a response cycle drops that response immediately.
    assign i_rvalid = i_rvalid_q && !rst;
    assign i_err    = i_err_q && !rst;
    assign d_rvalid = d_rvalid_q && !rst;
    assign d_err    = d_err_q && !rst;

`ifdef ARB_PERF_EN
    // Free-running wrap-around counters of fetch stalls and D grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_stall <= '0;
            perf_d_grant <= '0;
        end else begin
            perf_i_stall <= perf_i_stall + 32'(i_req && !i_gnt);
            perf_d_grant <= perf_d_grant + 32'(d_gnt);
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a byte-array reference of the memory and a simple
// priority/starvation model. Build with ARB_PERF_EN to also check counters.
module tb_imem_port_arbiter;

    localparam int unsigned          MAX_WAIT = 3;
    localparam longint unsigned      START_L  = 64'hbfc00000;
    localparam longint unsigned      MEM_L    = 4096;
    localparam logic [31:0]          START    = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_i_stall;
    logic [31:0] perf_d_grant;
`endif

    imem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .i_err       (i_err),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_be        (d_be),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .d_err       (d_err),
        .m_addr      (m_addr),
        .m_we        (m_we),
        .m_be        (m_be),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_i_stall(perf_i_stall),
        .perf_d_grant(perf_d_grant)
`endif
    );

    always #5 clk = ~clk;

    // Memory array seen by the DUT (big-endian words).
    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [11:0] mi;
    assign mi = m_addr[11:0] & 12'hFFC;

    always_comb m_rdata = {mem[mi], mem[mi + 12'd1], mem[mi + 12'd2], mem[mi + 12'd3]};

    always @(posedge clk) begin
        if (m_we) begin
            if (m_be[3]) mem[mi]          <= m_wdata[31:24];
            if (m_be[2]) mem[mi + 12'd1]  <= m_wdata[23:16];
            if (m_be[1]) mem[mi + 12'd2]  <= m_wdata[15:8];
            if (m_be[0]) mem[mi + 12'd3]  <= m_wdata[7:0];
        end
    end

    // Reference model state.
    int unsigned wait_m;
    bit          e_irv, e_ierr, e_drv, e_derr, rst_prev;
    logic [31:0] e_idata, e_ddata;
    int unsigned p_stall, p_dgnt;
    bit          last_ig, last_dg;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        longint unsigned w;
        w = {32'd0, a};
        w = w - (w % 4);
        return (w >= START_L) && (w + 4 <= START_L + MEM_L);
    endfunction

    function automatic int ref_off(input logic [31:0] a);
        longint unsigned w;
        w = {32'd0, a};
        w = w - (w % 4) - START_L;
        return int'(w);
    endfunction

    function automatic logic [31:0] ref_read(input int off);
        return {ref_mem[off], ref_mem[off + 1], ref_mem[off + 2], ref_mem[off + 3]};
    endfunction

    // One clock cycle: inputs are already applied; check, advance model, clock.
    task automatic step();
        bit ei, ed, iok, dok;
        int ioff, doff;
        #1;
        chk("i_rvalid", i_rvalid, e_irv && !rst);
        chk("d_rvalid", d_rvalid, e_drv && !rst);
        if (e_irv && !rst) begin
            chk("i_err", i_err, e_ierr);
            chk("i_rdata", i_rdata, e_idata);
        end
        if (e_drv && !rst) begin
            chk("d_err", d_err, e_derr);
            chk("d_rdata", d_rdata, e_ddata);
        end
        if (rst_prev) begin
            chk("i_rdata_rst", i_rdata, 32'h0);
            chk("d_rdata_rst", d_rdata, 32'h0);
        end
`ifdef ARB_PERF_EN
        chk("perf_i_stall", perf_i_stall, p_stall);
        chk("perf_d_grant", perf_d_grant, p_dgnt);
`endif
        ei   = !rst && i_req && (wait_m >= MAX_WAIT || !d_req);
        ed   = !rst && d_req && !ei;
        iok  = ref_in_range(i_addr);
        dok  = ref_in_range(d_addr);
        ioff = ref_off(i_addr);
        doff = ref_off(d_addr);
        chk("i_gnt", i_gnt, ei);
        chk("d_gnt", d_gnt, ed);
        chk("m_we", m_we, ed && d_we && dok);
        if (ei && iok) chk("m_addr_i", m_addr, ioff);
        if (ed && dok) chk("m_addr_d", m_addr, doff);
        last_ig = ei;
        last_dg = ed;
        if (rst) begin
            wait_m  = 0;
            e_irv   = 0; e_ierr = 0; e_idata = 0;
            e_drv   = 0; e_derr = 0; e_ddata = 0;
            p_stall = 0; p_dgnt = 0;
        end else begin
            if (i_req && !ei) wait_m = (wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT;
            else wait_m = 0;
            if (i_req && !ei) p_stall++;
            if (ed) p_dgnt++;
            e_irv  = ei;
            e_ierr = ei && !iok;
            if (ei) e_idata = iok ? ref_read(ioff) : 32'h0;
            e_drv  = ed;
            e_derr = ed && !dok;
            if (ed) begin
                e_ddata = (dok && !d_we) ? ref_read(doff) : 32'h0;
                if (dok && d_we) begin
                    if (d_be[3]) ref_mem[doff]     = d_wdata[31:24];
                    if (d_be[2]) ref_mem[doff + 1] = d_wdata[23:16];
                    if (d_be[1]) ref_mem[doff + 2] = d_wdata[15:8];
                    if (d_be[0]) ref_mem[doff + 3] = d_wdata[7:0];
                end
            end
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom % 8;
        if (r == 0) return $urandom;
        if (r == 1) return START + 32'd4096 + ($urandom % 16);
        if (r == 2) return START - 32'd1 - ($urandom % 8);
        return START + ($urandom % 4096);
    endfunction

    logic [7:0]  orig10, orig11;
    bit          gi_seq [5];
    logic [31:0] bnd    [5];

    initial begin
        for (int k = 0; k < 4096; k++) begin
            mem[k]     = 8'($urandom);
            ref_mem[k] = mem[k];
        end
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
        for (int k = 4; k < 8; k++) ref_mem[k] = mem[k];
        orig10 = ref_mem[16];
        orig11 = ref_mem[17];

        wait_m = 0; e_irv = 0; e_ierr = 0; e_drv = 0; e_derr = 0;
        e_idata = 0; e_ddata = 0; rst_prev = 1; p_stall = 0; p_dgnt = 0;
        last_ig = 0; last_dg = 0;

        // Reset with both requests asserted, then D wins first.
        rst = 1; i_req = 1; i_addr = START + 32'd8;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = START + 32'h20; d_wdata = 0;
        @(posedge clk); #1;
        step();
        step();
        rst = 0;
        step();
        chk("t1_first_d", {31'b0, last_dg}, 32'd1);
        d_req = 0;
        step();
        i_req = 0;
        step();

        // Fetch with unaligned address returns the big-endian word.
        i_req = 1; i_addr = 32'hbfc00006;
        step();
        i_req = 0;
        chk("t2_rvalid", {31'b0, i_rvalid}, 32'd1);
        chk("t2_rdata", i_rdata, 32'h11223344);
        chk("t2_err", {31'b0, i_err}, 32'd0);
        step();

        // Starvation guard: D, D, D, then I, then D again.
        i_req = 1; i_addr = START + 32'h40;
        d_req = 1; d_we = 0; d_addr = START + 32'h80;
        for (int k = 0; k < 5; k++) begin
            step();
            gi_seq[k] = last_ig;
        end
        chk("t3_seq", {27'b0, gi_seq[0], gi_seq[1], gi_seq[2], gi_seq[3], gi_seq[4]}, 32'b00010);
        i_req = 0; d_req = 0;
        step();

        // Partial store then immediate load of the same word.
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h1234BEEF; d_addr = 32'hbfc00010;
        step();
        d_we = 0;
        step();
        d_req = 0;
        step();
        chk("t4_low", {16'b0, d_rdata[15:0]}, 32'h0000BEEF);
        chk("t4_high", {16'b0, d_rdata[31:16]}, {16'b0, orig10, orig11});

        // Out-of-range store and fetch.
        d_req = 1; d_we = 1; d_be = 4'hF; d_wdata = 32'hDEADBEEF; d_addr = 32'hbfc01000;
        step();
        chk("t5_d_err", {31'b0, d_err}, 32'd1);
        d_req = 0; i_req = 1; i_addr = 32'h0;
        step();
        chk("t5_i_err", {31'b0, i_err}, 32'd1);
        i_req = 0;

        // Range boundaries on loads.
        bnd[0] = START + 32'd4092; bnd[1] = START + 32'd4095; bnd[2] = START + 32'd4096;
        bnd[3] = START - 32'd1;    bnd[4] = 32'hFFFF_FFFC;
        d_we = 0; d_req = 1;
        for (int k = 0; k < 5; k++) begin
            d_addr = bnd[k];
            step();
        end
        d_req = 0;
        step();

        // Reset right after a fetch grant drops the response.
        i_req = 1; i_addr = START + 32'h100;
        step();
        i_req = 0; rst = 1;
        #1;
        chk("t6_rvalid", {31'b0, i_rvalid}, 32'd0);
        step();
`ifdef ARB_PERF_EN
        chk("t6_perf_stall", perf_i_stall, 32'd0);
        chk("t6_perf_dgnt", perf_d_grant, 32'd0);
`endif
        rst = 0;
        step();

        // Random traffic obeying the hold-until-grant handshake.
        for (int n = 0; n < 400; n++) begin
            if (!(i_req && !last_ig) || rst) begin
                i_req  = ($urandom % 3) != 0;
                i_addr = rand_addr();
            end
            if (!(d_req && !last_dg) || rst) begin
                d_req   = ($urandom % 2) != 0;
                d_we    = ($urandom % 2) != 0;
                d_be    = 4'($urandom);
                d_addr  = rand_addr();
                d_wdata = $urandom;
            end
            rst = ($urandom % 60) == 0;
            step();
        end
        rst = 0; i_req = 0; d_req = 0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
